// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared types and constants for the Hack CPU control core
package hack_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 15;

    localparam int IS_C     = 15;
    localparam int A_SEL    = 12;
    localparam int CTRL_MSB = 11;
    localparam int CTRL_LSB = 6;
    localparam int D_A      = 5;
    localparam int D_D      = 4;
    localparam int D_M      = 3;
    localparam int J1       = 2;
    localparam int J2       = 1;
    localparam int J3       = 0;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/hack_jump_cond.sv
// rtl/hack_jump_cond.sv - combinational jump decision from jump bits and ALU flags
module hack_jump_cond
    import hack_pkg::*;
(
    input  logic [2:0] i_j,
    input  logic       i_zr,
    input  logic       i_ng,
    output logic       o_jump
);

    // j1 = less than zero, j2 = equal to zero, j3 = strictly positive
    assign o_jump = (i_j[J1] & i_ng)
                  | (i_j[J2] & i_zr)
                  | (i_j[J3] & ~i_ng & ~i_zr);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// rtl/hack_cpu_ctrl.sv - Hack CPU fetch/execute control, A/D/PC registers and ALU driving
module hack_cpu_ctrl
    import hack_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic              instr_req,
    output logic [ADDR_W-1:0] pc,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] instruction,
    input  logic [DATA_W-1:0] inM,
    output logic [ADDR_W-1:0] addressM,
    output logic [DATA_W-1:0] outM,
    output logic              writeM,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic              alu_zx,
    output logic              alu_nx,
    output logic              alu_zy,
    output logic              alu_ny,
    output logic              alu_f,
    output logic              alu_no,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zr,
    input  logic              alu_ng
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_d;
    logic [DATA_W-1:0] r_ir;

    logic              w_exec;
    logic              w_is_c;
    logic              w_exec_c;
    logic              w_m_dest;
    logic              w_commit;
    logic              w_jump;
    logic [ADDR_W-1:0] w_pc_next;
    logic [5:0]        w_ctrl;

    assign w_exec   = (r_state == EXEC);
    assign w_is_c   = r_ir[IS_C];
    assign w_exec_c = w_exec & w_is_c;
    assign w_m_dest = w_exec_c & r_ir[D_M];

    // A stalled M write holds every register until the RAM takes the data
    assign w_commit = w_exec & (~w_m_dest | mem_ready);

    hack_jump_cond u_jump_cond (
        .i_j    (r_ir[J1:J3]),
        .i_zr   (alu_zr),
        .i_ng   (alu_ng),
        .o_jump (w_jump)
    );

    assign w_pc_next = (w_is_c && w_jump) ? r_a[ADDR_W-1:0] : pc_inc(r_pc);

    assign w_ctrl = w_exec_c ? r_ir[CTRL_MSB:CTRL_LSB] : 6'b0;
    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = w_ctrl;

    assign alu_x = r_d;
    assign alu_y = (w_exec_c && r_ir[A_SEL]) ? inM : r_a;

    assign instr_req = (r_state == FETCH) & ~reset;
    assign writeM    = w_m_dest & ~reset;
    assign addressM  = r_a[ADDR_W-1:0];
    assign outM      = alu_out;
    assign pc        = r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_pc    <= '0;
            r_a     <= '0;
            r_d     <= '0;
            r_ir    <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (instr_valid) begin
                        r_ir    <= instruction;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (w_commit) begin
                        r_state <= FETCH;
                        r_pc    <= w_pc_next;
                        if (!w_is_c) begin
                            r_a <= r_ir;
                        end else begin
                            if (r_ir[D_A]) r_a <= alu_out;
                            if (r_ir[D_D]) r_d <= alu_out;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// tb/tb_hack_cpu_ctrl.sv - scoreboard bench for hack_cpu_ctrl with ALU and RAM models
module tb_hack_cpu_ctrl;

    logic        clk;
    logic        reset;
    logic        instr_req;
    logic [14:0] pc;
    logic        instr_valid;
    logic [15:0] instruction;
    logic [15:0] inM;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic        mem_ready;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic        alu_zr, alu_ng;

    hack_cpu_ctrl dut (
        .clk(clk), .reset(reset), .instr_req(instr_req), .pc(pc),
        .instr_valid(instr_valid), .instruction(instruction), .inM(inM),
        .addressM(addressM), .outM(outM), .writeM(writeM), .mem_ready(mem_ready),
        .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_nx(alu_nx),
        .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0 : x;
        xx = c[4] ? ~xx : xx;
        yy = c[3] ? 16'h0 : y;
        yy = c[2] ? ~yy : yy;
        o  = c[1] ? (xx + yy) : (xx & yy);
        return c[0] ? ~o : o;
    endfunction

    assign alu_out = alu_fn(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    assign alu_zr  = (alu_out == 16'h0);
    assign alu_ng  = alu_out[15];

    logic [15:0] ram [0:63];
    assign inM = ram[addressM[5:0]];
    always @(posedge clk) if (!reset && writeM && mem_ready) ram[addressM[5:0]] <= outM;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [14:0] pc; logic [15:0] a; logic [15:0] d; } exp_t;
    typedef struct { logic [14:0] addr; logic [15:0] data; } wr_t;
    exp_t exp_q[$];
    wr_t  wr_q[$];

    logic [15:0] m_a, m_d;
    logic [14:0] m_pc;
    logic [5:0]  last_ctrl;
    logic [15:0] last_y;
    int          wm_cycles;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic [15:0] ins, output logic has_mw);
        logic [15:0] y, res;
        logic jmp;
        exp_t e;
        wr_t w;
        has_mw = 1'b0;
        if (!ins[15]) begin
            m_a  = ins;
            m_pc = m_pc + 15'd1;
        end else begin
            y   = ins[12] ? ram[m_a[5:0]] : m_a;
            res = alu_fn(m_d, y, ins[11:6]);
            jmp = (ins[2] & res[15]) | (ins[1] & (res == 16'h0))
                | (ins[0] & ~res[15] & (res != 16'h0));
            if (ins[3]) begin
                w.addr = m_a[14:0];
                w.data = res;
                wr_q.push_back(w);
                has_mw = 1'b1;
            end
            m_pc = jmp ? m_a[14:0] : m_pc + 15'd1;
            if (ins[5]) m_a = res;
            if (ins[4]) m_d = res;
        end
        e.pc = m_pc; e.a = m_a; e.d = m_d;
        exp_q.push_back(e);
    endtask

    task automatic exec_instr(input logic [15:0] ins, input int gap, input int stall);
        logic has_mw, committing, first;
        logic [14:0] old_pc;
        exp_t e;
        wr_t w;
        int k;
        k = 0;
        while (instr_req !== 1'b1 && k < 20) begin step(); k++; end
        n_checks++;
        if (instr_req !== 1'b1) begin n_fail++; $display("FAIL fetch_wait: instr_req=%b required 1", instr_req); end
        for (int g = 0; g < gap; g++) begin
            instr_valid = 1'b0;
            instruction = 16'($urandom);
            #1;
            n_checks++;
            if (pc !== m_pc) begin n_fail++; $display("FAIL gap_pc: got %h required %h", pc, m_pc); end
            step();
        end
        old_pc = m_pc;
        model_step(ins, has_mw);
        instruction = ins;
        instr_valid = 1'b1;
        step();
        wm_cycles = 0;
        first = 1'b1;
        for (int c = 0; c < 40; c++) begin
            instr_valid = 1'($urandom_range(0, 1));
            instruction = 16'($urandom);
            mem_ready   = (c >= stall);
            #1;
            if (first) begin
                last_ctrl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
                last_y    = alu_y;
                first     = 1'b0;
            end
            if (writeM === 1'b1) wm_cycles++;
            n_checks++;
            if (writeM !== has_mw) begin n_fail++; $display("FAIL writeM: got %b required %b", writeM, has_mw); end
            if (writeM === 1'b1 && mem_ready) begin
                n_checks++;
                if (wr_q.size() == 0) begin
                    n_fail++; $display("FAIL wr_unexpected: write to %h with empty scoreboard", addressM);
                end else begin
                    w = wr_q.pop_front();
                    if (addressM !== w.addr || outM !== w.data) begin
                        n_fail++;
                        $display("FAIL wr_data: got addr %h data %h required addr %h data %h", addressM, outM, w.addr, w.data);
                    end
                end
            end
            committing = mem_ready || !has_mw;
            if (!committing) begin
                n_checks++;
                if (pc !== old_pc) begin n_fail++; $display("FAIL stall_pc: got %h required %h", pc, old_pc); end
            end
            step();
            if (committing) break;
        end
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL exp_empty: no expected state");
        end else begin
            e = exp_q.pop_front();
            if (pc !== e.pc || alu_y !== e.a || alu_x !== e.d || instr_req !== 1'b1) begin
                n_fail++;
                $display("FAIL state: got pc %h A %h D %h req %b required pc %h A %h D %h req 1",
                         pc, alu_y, alu_x, instr_req, e.pc, e.a, e.d);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0; instruction = 16'h0;
        step();
        n_checks++;
        if (instr_req !== 1'b0 || writeM !== 1'b0) begin
            n_fail++; $display("FAIL reset_gate: got req %b wm %b required 0 0", instr_req, writeM);
        end
        step();
        n_checks++;
        if (pc !== 15'h0 || addressM !== 15'h0 || alu_x !== 16'h0 || alu_y !== 16'h0) begin
            n_fail++; $display("FAIL reset_regs: got pc %h A %h D %h required 0 0 0", pc, alu_y, alu_x);
        end
        n_checks++;
        if (instr_req !== 1'b0 || writeM !== 1'b0) begin
            n_fail++; $display("FAIL reset_gate2: got req %b wm %b required 0 0", instr_req, writeM);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (instr_req !== 1'b1) begin n_fail++; $display("FAIL reset_release: instr_req=%b required 1", instr_req); end
        m_a = 16'h0; m_d = 16'h0; m_pc = 15'h0;
    endtask

    task automatic test_a_then_d();
        int t0;
        t0 = cyc;
        exec_instr(16'h0005, 0, 0);
        exec_instr(16'hEC10, 0, 0);
        n_checks++;
        if (last_ctrl !== 6'b110000 || last_y !== 16'h0005) begin
            n_fail++; $display("FAIL d_eq_a_ctrl: got ctrl %b y %h required 110000 0005", last_ctrl, last_y);
        end
        n_checks++;
        if (cyc - t0 != 4 || pc !== 15'd2 || alu_x !== 16'h5 || alu_y !== 16'h5) begin
            n_fail++; $display("FAIL d_eq_a_state: got cycles %0d pc %h A %h D %h required 4 0002 0005 0005", cyc - t0, pc, alu_y, alu_x);
        end
    endtask

    task automatic test_mwrite();
        exec_instr(16'h0007, 0, 0);
        exec_instr(16'hEC10, 1, 0);
        exec_instr(16'h0010, 0, 0);
        exec_instr(16'hE7C8, 0, 3);
        n_checks++;
        if (wm_cycles != 4 || ram[16] !== 16'h0008) begin
            n_fail++; $display("FAIL m_write: got wm cycles %0d ram %h required 4 0008", wm_cycles, ram[16]);
        end
    endtask

    task automatic test_jump();
        logic [14:0] p;
        exec_instr(16'h0123, 0, 0);
        exec_instr(16'hEA90, 0, 0);
        p = pc;
        exec_instr(16'hE301, 0, 2);
        n_checks++;
        if (pc !== p + 15'd1) begin n_fail++; $display("FAIL jgt_zero: got %h required %h", pc, p + 15'd1); end
        exec_instr(16'hEFD0, 0, 0);
        exec_instr(16'hE301, 2, 0);
        n_checks++;
        if (pc !== 15'h0123) begin n_fail++; $display("FAIL jgt_pos: got %h required 0123", pc); end
        exec_instr(16'hEE90, 0, 0);
        p = pc;
        exec_instr(16'hE301, 0, 0);
        n_checks++;
        if (pc !== p + 15'd1) begin n_fail++; $display("FAIL jgt_neg: got %h required %h", pc, p + 15'd1); end
    endtask

    task automatic test_wrap();
        exec_instr(16'h7FFF, 0, 0);
        exec_instr(16'hEA87, 0, 0);
        n_checks++;
        if (pc !== 15'h7FFF) begin n_fail++; $display("FAIL jmp_top: got %h required 7fff", pc); end
        exec_instr(16'h0005, 0, 0);
        n_checks++;
        if (pc !== 15'h0000) begin n_fail++; $display("FAIL pc_wrap: got %h required 0000", pc); end
        exec_instr(16'h4002, 0, 0);
        exec_instr(16'hEC10, 0, 0);
        exec_instr(16'hE0A0, 0, 0);
        n_checks++;
        if (alu_y !== 16'h8004) begin n_fail++; $display("FAIL a_msb: got %h required 8004", alu_y); end
        exec_instr(16'hEA87, 0, 0);
        n_checks++;
        if (pc !== 15'h0004) begin n_fail++; $display("FAIL jmp_trunc: got %h required 0004", pc); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++)
            exec_instr(16'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    endtask

    task automatic test_reset_stall();
        logic [15:0] d_before, ram_before;
        logic [5:0]  idx;
        int k;
        k = 0;
        while (instr_req !== 1'b1 && k < 20) begin step(); k++; end
        d_before   = m_d;
        idx        = m_a[5:0];
        ram_before = ram[idx];
        instruction = 16'hE7C8;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        #1;
        n_checks++;
        if (writeM !== 1'b1) begin n_fail++; $display("FAIL stall_wm: got %b required 1", writeM); end
        step();
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (writeM !== 1'b0 || instr_req !== 1'b0 || alu_x !== d_before) begin
            n_fail++; $display("FAIL rst_stall_gate: got wm %b req %b D %h required 0 0 %h", writeM, instr_req, alu_x, d_before);
        end
        step();
        reset     = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (pc !== 15'h0 || alu_x !== 16'h0 || alu_y !== 16'h0 || instr_req !== 1'b1 || ram[idx] !== ram_before) begin
            n_fail++; $display("FAIL rst_stall_after: got pc %h D %h A %h req %b ram %h required 0 0 0 1 %h",
                               pc, alu_x, alu_y, instr_req, ram[idx], ram_before);
        end
        wr_q.delete();
        m_a = 16'h0; m_d = 16'h0; m_pc = 15'h0;
        exec_instr(16'h0021, 0, 0);
        exec_instr(16'hEFC8, 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 16'(i * 3 + 1);
        test_reset();
        test_a_then_d();
        test_mwrite();
        test_jump();
        test_wrap();
        test_back_to_back();
        test_reset_stall();
        n_checks++;
        if (exp_q.size() != 0 || wr_q.size() != 0) begin
            n_fail++; $display("FAIL leftover: got %0d states %0d writes pending required 0 0", exp_q.size(), wr_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
